// File: rtl/vr_fifo_channel.sv
// Valid/ready channel buffered by a DEPTH-entry first-word-fall-through FIFO,
// with occupancy, almost-full, synchronous flush and a wrapping transfer counter.
module vr_fifo_channel #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = 6,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic [CNT_W-1:0]         xfer_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;
   logic              af_q;
   logic              rdy_en_q;
   logic [CNT_W-1:0]  xfer_q;
   logic              push;
   logic              pop;

   // rdy_en_q keeps in_ready low until the first edge after reset release
   assign in_ready    = rdy_en_q & (cnt_q != CW'(DEPTH)) & ~flush;
   assign out_valid   = (cnt_q != '0);
   assign out_data    = out_valid ? mem[rd_ptr] : '0;
   assign count       = cnt_q;
   assign almost_full = af_q;
   assign xfer_cnt    = xfer_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready & ~flush;

   // next occupancy
   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else begin
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // pointer, occupancy and counter state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt_q    <= '0;
         af_q     <= 1'b0;
         rdy_en_q <= 1'b0;
         xfer_q   <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         cnt_q    <= cnt_d;
         af_q     <= (cnt_d >= CW'(AF_LEVEL));
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
         if (pop) xfer_q <= xfer_q + CNT_W'(1);
      end
   end

   // storage needs no reset: out_data is masked while empty
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule
